avf_epoch_acc: RTL and testbench
================================

Name: avf_epoch_acc

Overview:
- Parametrised multi-channel AVF accumulator; successor to the fixed per-structure accumulators.
- Each cycle, every lane may contribute a vulnerability product, duration x vbit-count, to one saturating accumulator.
- Accumulation runs over fixed-length epochs, or shorter ones cut by flush. Each closed epoch is published as a snapshot on a valid/ready port.
- Sits downstream of the duration trackers and VLT lookups; feeds the AVF readout/CSR logic.

Parameters:
- NUM_CH, 4: number of input lanes.
- DUR_W, 10: duration width per lane.
- VB_W, 8: vbit-count width per lane.
- ACC_W, 25: accumulator and snapshot width.
- EPOCH_LEN, 256: cycles per epoch, >=2.
- EPOCH_W, $clog2(EPOCH_LEN+1): derived; width of the cycle count. Not overridden.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: run accumulation.
- flush, in, 1: close the current epoch at the end of this cycle.
- in_valid, in, NUM_CH: per-lane contribution valid.
- in_duration, in, NUM_CH*DUR_W: lane i at [i*DUR_W +: DUR_W].
- in_vbits, in, NUM_CH*VB_W: lane i at [i*VB_W +: VB_W].
- snap_valid, out, 1: snapshot available.
- snap_ready, in, 1: consumer accepts the snapshot.
- snap_acc, out, ACC_W: epoch AVF sum.
- snap_cycles, out, EPOCH_W: cycles in the epoch.
- snap_sat, out, 1: accumulator saturated during the epoch.
- overrun, out, 1: sticky; a snapshot was dropped.
- busy, out, 1: FSM not IDLE, or a pipeline marker in flight.

Behaviour:
- Reset (async assert, low): all outputs 0; FSM IDLE; epoch counter, accumulator, pipeline regs and sat flag 0. Any pending snapshot is lost.
- FSM IDLE -> RUN: enable=1. The first RUN cycle is epoch cycle 0; overrun clears on this transition.
- FSM RUN -> STOP: enable=0. That cycle is treated as an epoch end.
- FSM STOP -> IDLE: once the end marker has left stage 2. Inputs are ignored in STOP and IDLE.
- In RUN, every cycle's inputs are captured; the epoch counter increments.
- Epoch end: counter==EPOCH_LEN-1, or flush, or enable falling. The counter returns to 0. flush on the natural end cycle gives one epoch end only. flush in IDLE or STOP is ignored.
- Stage 1 (registered): prod_i = in_valid[i] ? in_duration_i * in_vbits_i : 0, width DUR_W+VB_W. Also carries end marker and cycle count = counter+1.
- Stage 2 (registered): sum = sum of prod_i, width DUR_W+VB_W+$clog2(NUM_CH). acc_next = acc+sum, clamped to 2^ACC_W-1; sat_flag set on clamp.
- On marker in stage 2: candidate = {acc_next, cycles, sat_flag | clamp}. Then acc <= 0 and sat_flag <= 0. Contributions from the end cycle belong to the closing epoch.
- Latency: inputs on epoch-end cycle t -> snap_valid=1 at t+3.
- Snapshot register: loaded if snap_valid=0, or snap_valid & snap_ready in the same cycle; snap_valid=1 next cycle.
- If the snapshot is held and not accepted: candidate dropped, overrun<=1, old data unchanged.
- Handshake: snap_valid holds and data stays stable until snap_ready; clear on snap_valid & snap_ready with no new load.
- Zero-valid epochs still publish (snap_acc=0).

Optional Feature:
- Macro AVF_ACC_PARITY_EN.
- When defined: extra output snap_parity (1 bit) = even parity over {snap_sat, snap_cycles, snap_acc}, registered together with the snapshot. Reset value 0.
- When undefined: the port and logic are absent.

Decomposition:
- Package avf_acc_pkg: state enum (IDLE, RUN, STOP); snapshot struct typedef (acc, cycles, sat); sat_add function.
- Sub-module avf_prod_sum: stage-1 multipliers plus stage-2 lane adder tree, parametrised by NUM_CH/DUR_W/VB_W.
- Top holds the FSM, epoch counter, accumulator and snapshot register.

Test Plan:
- EPOCH_LEN=8, NUM_CH=4, all lanes valid, dur=3, vbits=2, snap_ready=1 for 8 cycles -> snap_acc=192, snap_cycles=8, snap_sat=0; snap_valid 3 cycles after the 8th input.
- Defaults, all lanes dur=1023, vbits=255 for a full 256-cycle epoch -> snap_acc=33554431, snap_sat=1; next epoch with zero inputs -> snap_acc=0, snap_sat=0.
- EPOCH_LEN=8, flush on epoch cycle 3, lane0 dur=5, vbits=1 each cycle -> snap_acc=20, snap_cycles=4; following epoch starts at count 0.
- EPOCH_LEN=8, snap_ready=0 across two epoch ends -> first snapshot held unchanged, overrun=1; dropping enable then re-raising clears overrun.
- reset asserted mid-epoch with snap_valid=1 -> all outputs 0 immediately; after release plus enable, first snapshot covers only post-reset inputs.
- AVF_ACC_PARITY_EN defined, snapshot acc=192, cycles=8, sat=0 -> snap_parity=1 (three ones).

Source files
------------

// File: rtl/avf_acc_pkg.sv
// avf_acc_pkg: shared types and the saturating adder for the AVF epoch accumulator.
package avf_acc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int SNAP_ACC_MAX_W = 32;
  localparam int SNAP_CYC_MAX_W = 16;
  // Sized for the widest supported configuration; the top zero-extends into it.
  typedef struct packed {
    logic [SNAP_ACC_MAX_W-1:0] acc;
    logic [SNAP_CYC_MAX_W-1:0] cycles;
    logic                      sat;
  } snap_t;
  // Returns {clamped, value} with value limited to 2^w-1.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? {1'b1, m[63:0]} : {1'b0, s[63:0]};
  endfunction
endpackage

// File: rtl/avf_prod_sum.sv
// avf_prod_sum: per-lane duration x vbit products (stage 1) and their lane sum (stage 2).
module avf_prod_sum
  import avf_acc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DUR_W  = 10,
  parameter int VB_W   = 8,
  localparam int PROD_W = DUR_W + VB_W,
  localparam int SUM_W  = PROD_W + $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cap,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*DUR_W-1:0] in_duration,
  input  logic [NUM_CH*VB_W-1:0]  in_vbits,
  output logic [SUM_W-1:0]        sum_q
);
  logic [PROD_W-1:0] prod_d [NUM_CH];
  logic [PROD_W-1:0] prod_q [NUM_CH];
  logic [SUM_W-1:0]  sum_d;
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      prod_d[i] = (cap && in_valid[i]) ?
        PROD_W'(in_duration[i*DUR_W +: DUR_W]) * PROD_W'(in_vbits[i*VB_W +: VB_W]) : '0;
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '{default: '0};
      sum_q  <= '0;
    end else begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
    end
  end
endmodule

// File: rtl/avf_epoch_acc.sv
// avf_epoch_acc: multi-lane saturating AVF accumulator publishing per-epoch snapshots on valid/ready.
// Define AVF_ACC_PARITY_EN to add snap_parity (even parity over sat, cycles, acc).
module avf_epoch_acc
  import avf_acc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DUR_W     = 10,
  parameter int VB_W      = 8,
  parameter int ACC_W     = 25,
  parameter int EPOCH_LEN = 256,
  localparam int EPOCH_W  = $clog2(EPOCH_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*DUR_W-1:0] in_duration,
  input  logic [NUM_CH*VB_W-1:0]  in_vbits,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [ACC_W-1:0]        snap_acc,
  output logic [EPOCH_W-1:0]      snap_cycles,
  output logic                    snap_sat,
  output logic                    overrun,
  output logic                    busy
`ifdef AVF_ACC_PARITY_EN
  , output logic                  snap_parity
`endif
);
  localparam int SUM_W = DUR_W + VB_W + $clog2(NUM_CH);
  state_t             state_q, state_d;
  logic [EPOCH_W-1:0] cnt_q, cnt_d, s1_cyc_q, s1_cyc_d, s2_cyc_q;
  logic               s1_mark_q, s1_mark_d, s2_mark_q;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
  logic               sat_q, sat_d, clamp;
  snap_t              snap_q, snap_d, cand;
  logic               snap_valid_q, snap_valid_d, overrun_q, overrun_d;
  logic               parity_q, parity_d;
  logic               run, ep_end, load;
  logic [64:0]        add_r;
  logic [SUM_W-1:0]   lane_sum;
  logic               unused_ok;

  avf_prod_sum #(.NUM_CH(NUM_CH), .DUR_W(DUR_W), .VB_W(VB_W)) u_prod_sum (
    .clk(clk), .reset(reset), .cap(run), .in_valid(in_valid),
    .in_duration(in_duration), .in_vbits(in_vbits), .sum_q(lane_sum)
  );

  always_comb begin
    run = state_q == RUN;
    ep_end = run && (cnt_q == EPOCH_W'(EPOCH_LEN - 1) || flush || !enable);
    state_d = (state_q == IDLE) ? (enable ? RUN : IDLE) :
              run ? (enable ? RUN : STOP) :
              (s2_mark_q && !s1_mark_q) ? IDLE : STOP;
    cnt_d = (run && !ep_end) ? cnt_q + EPOCH_W'(1) : '0;
    s1_mark_d = ep_end;
    s1_cyc_d = run ? cnt_q + EPOCH_W'(1) : '0;
    add_r = sat_add(64'(acc_q), 64'(lane_sum), ACC_W);
    acc_next = add_r[ACC_W-1:0];
    clamp = add_r[64];
    cand = '0;
    cand.acc = SNAP_ACC_MAX_W'(acc_next);
    cand.cycles = SNAP_CYC_MAX_W'(s2_cyc_q);
    cand.sat = sat_q || clamp;
    // The end-cycle contribution closes with its epoch; the next epoch starts from zero.
    acc_d = s2_mark_q ? '0 : acc_next;
    sat_d = !s2_mark_q && (sat_q || clamp);
    load = s2_mark_q && (!snap_valid_q || snap_ready);
    snap_d = load ? cand : snap_q;
    snap_valid_d = load || (snap_valid_q && !snap_ready);
    overrun_d = (s2_mark_q && !load) || (overrun_q && !(state_q == IDLE && enable));
    parity_d = load ? ^cand : parity_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s1_mark_q    <= 1'b0;
      s1_cyc_q     <= '0;
      s2_mark_q    <= 1'b0;
      s2_cyc_q     <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      parity_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_mark_q    <= s1_mark_d;
      s1_cyc_q     <= s1_cyc_d;
      s2_mark_q    <= s1_mark_q;
      s2_cyc_q     <= s1_cyc_q;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      overrun_q    <= overrun_d;
      parity_q     <= parity_d;
    end
  end

  assign snap_valid  = snap_valid_q;
  assign snap_acc    = snap_q.acc[ACC_W-1:0];
  assign snap_cycles = snap_q.cycles[EPOCH_W-1:0];
  assign snap_sat    = snap_q.sat;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE) || s1_mark_q || s2_mark_q;
  assign unused_ok   = ^{snap_q, add_r, parity_q};
`ifdef AVF_ACC_PARITY_EN
  assign snap_parity = parity_q;
`endif
endmodule

// File: tb/tb_avf_epoch_acc.sv
// tb_avf_epoch_acc: directed test-plan scenarios plus randomized traffic against an epoch-level model.
module tb_avf_epoch_acc;
  localparam int NUM_CH = 4, DUR_W = 10, VB_W = 8, ACC_W = 22, EPOCH_LEN = 8;
  localparam int EPOCH_W = $clog2(EPOCH_LEN + 1);
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic clk = 0, reset = 1, enable = 0, flush = 0, snap_ready = 0;
  logic [NUM_CH-1:0]       in_valid = '0;
  logic [NUM_CH*DUR_W-1:0] in_duration = '0;
  logic [NUM_CH*VB_W-1:0]  in_vbits = '0;
  logic                    snap_valid, snap_sat, overrun, busy;
  logic [ACC_W-1:0]        snap_acc;
  logic [EPOCH_W-1:0]      snap_cycles;
`ifdef AVF_ACC_PARITY_EN
  logic                    snap_parity;
`endif

  always #5 clk = ~clk;

  avf_epoch_acc #(.NUM_CH(NUM_CH), .DUR_W(DUR_W), .VB_W(VB_W), .ACC_W(ACC_W), .EPOCH_LEN(EPOCH_LEN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_duration(in_duration), .in_vbits(in_vbits), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_acc(snap_acc), .snap_cycles(snap_cycles), .snap_sat(snap_sat), .overrun(overrun), .busy(busy)
`ifdef AVF_ACC_PARITY_EN
    , .snap_parity(snap_parity)
`endif
  );

  typedef struct {int due; longint acc; int cyc; bit sat;} snap_m_t;
  snap_m_t pend[$];
  int cyc = 0, idle_from = 0, n = 0, checks = 0, passed = 0, m_cyc = 0;
  longint tot = 0, m_acc = 0;
  bit m_run = 0, mv = 0, m_sat = 0, m_ovr = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_clear();
    m_run = 0; idle_from = 0; tot = 0; n = 0; mv = 0; m_acc = 0; m_cyc = 0; m_sat = 0; m_ovr = 0;
    pend.delete();
  endtask

  // Epoch bookkeeping from the current inputs; snapshots land two edges after their end cycle.
  task automatic model_edge();
    snap_m_t p;
    longint s = 0;
    if (m_run) begin
      for (int i = 0; i < NUM_CH; i++)
        if (in_valid[i]) s += longint'(in_duration[i*DUR_W +: DUR_W]) * longint'(in_vbits[i*VB_W +: VB_W]);
      tot += s;
      n++;
      if (n == EPOCH_LEN || flush || !enable) begin
        pend.push_back('{cyc + 2, (tot > ACC_MAX) ? ACC_MAX : tot, n, tot > ACC_MAX});
        tot = 0;
        n = 0;
        if (!enable) begin m_run = 0; idle_from = cyc + 3; end
      end
    end else if (cyc >= idle_from && enable) begin
      m_run = 1;
      m_ovr = 0;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      if (!mv || snap_ready) begin mv = 1; m_acc = p.acc; m_cyc = p.cyc; m_sat = p.sat; end
      else m_ovr = 1;
    end else if (mv && snap_ready) mv = 0;
  endtask

  task automatic check_outputs();
    check("snap_valid", snap_valid, mv);
    check("snap_acc", snap_acc, m_acc);
    check("snap_cycles", snap_cycles, m_cyc);
    check("snap_sat", snap_sat, m_sat);
    check("overrun", overrun, m_ovr);
    check("busy", busy, m_run || cyc < idle_from || pend.size() > 0);
`ifdef AVF_ACC_PARITY_EN
    check("snap_parity", snap_parity, ^{m_sat, m_cyc[EPOCH_W-1:0], m_acc[ACC_W-1:0]});
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic set_all(input bit [NUM_CH-1:0] v, input int d, input int b);
    in_valid = v;
    for (int i = 0; i < NUM_CH; i++) begin
      in_duration[i*DUR_W +: DUR_W] = DUR_W'(d);
      in_vbits[i*VB_W +: VB_W] = VB_W'(b);
    end
  endtask

  // Leaves the DUT in its first RUN cycle (epoch cycle 0).
  task automatic restart();
    enable = 0;
    repeat (3) tick();
    enable = 1;
    tick();
  endtask

  initial begin
    #1 reset = 0;
    @(posedge clk);
    #1;
    model_clear();
    check_outputs();
    check("rst_busy", busy, 0);
    @(negedge clk) reset = 1;

    // 8 cycles x 4 lanes x 3 x 2 = 192, visible three cycles after the 8th input
    snap_ready = 1;
    enable = 1;
    tick();
    set_all('1, 3, 2);
    repeat (8) tick();
    set_all('0, 0, 0);
    check("tp1_early", snap_valid, 0);
    tick();
    check("tp1_early2", snap_valid, 0);
    tick();
    check("tp1_valid", snap_valid, 1);
    check("tp1_acc", snap_acc, 192);
    check("tp1_cycles", snap_cycles, 8);
    check("tp1_sat", snap_sat, 0);

    // saturation, then a zero epoch
    restart();
    set_all('1, 1023, 255);
    repeat (8) tick();
    set_all('0, 0, 0);
    repeat (2) tick();
    check("tp2_acc", snap_acc, 4194303);
    check("tp2_sat", snap_sat, 1);
    repeat (8) tick();
    check("tp2_zero_valid", snap_valid, 1);
    check("tp2_zero_acc", snap_acc, 0);
    check("tp2_zero_sat", snap_sat, 0);

    // flush on epoch cycle 3
    restart();
    set_all(4'b0001, 5, 1);
    repeat (3) tick();
    flush = 1;
    tick();
    flush = 0;
    set_all('0, 0, 0);
    repeat (2) tick();
    check("tp3_acc", snap_acc, 20);
    check("tp3_cycles", snap_cycles, 4);
    repeat (8) tick();
    check("tp3_next_cycles", snap_cycles, 8);

    // held snapshot, second candidate dropped
    restart();
    snap_ready = 0;
    set_all('1, 2, 1);
    repeat (8) tick();
    set_all('1, 4, 1);
    repeat (8) tick();
    repeat (2) tick();
    check("tp4_valid", snap_valid, 1);
    check("tp4_acc_held", snap_acc, 64);
    check("tp4_ovr", overrun, 1);
    snap_ready = 1;
    restart();
    check("tp4_ovr_clear", overrun, 0);

    // reset mid-epoch with a snapshot pending
    snap_ready = 0;
    set_all('1, 7, 3);
    repeat (10) tick();
    check("tp5_pre_valid", snap_valid, 1);
    reset = 0;
    #1;
    model_clear();
    check("tp5_rst_valid", snap_valid, 0);
    check("tp5_rst_acc", snap_acc, 0);
    check("tp5_rst_busy", busy, 0);
    check_outputs();
    @(negedge clk) reset = 1;
    snap_ready = 1;
    enable = 1;
    tick();
    set_all('1, 1, 1);
    repeat (8) tick();
    set_all('0, 0, 0);
    repeat (2) tick();
    check("tp5_post_acc", snap_acc, 32);
    check("tp5_post_cycles", snap_cycles, 8);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_duration[i*DUR_W +: DUR_W] = ($urandom_range(0, 3) == 0) ? '1 : DUR_W'($urandom);
        in_vbits[i*VB_W +: VB_W] = VB_W'($urandom);
      end
      flush = ($urandom_range(0, 11) == 0);
      snap_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      tick();
    end
    flush = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
